// File: rtl/jtag_dmi_arb_if.sv
// Bundle of requester-side and debug-module-side DMI handshakes for jtag_dmi_arb.
// Signal names take the arbiter's point of view; slave is the arbiter, master is its environment.
interface jtag_dmi_arb_if #(
  parameter int DMI_ADDR_BITS = 7,
  parameter int DMI_DATA_BITS = 32,
  parameter int DMI_OP_BITS   = 2,
  parameter int NUM_REQ       = 2
) ();
  localparam int W = DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS;

  logic [NUM_REQ-1:0]   req_valid_i;
  logic [NUM_REQ*W-1:0] req_data_i;
  logic [NUM_REQ-1:0]   req_ready_o;
  logic [NUM_REQ-1:0]   resp_valid_o;
  logic [W-1:0]         resp_data_o;
  logic [NUM_REQ-1:0]   resp_ready_i;
  logic                 dmi_req_valid_o;
  logic [W-1:0]         dmi_req_data_o;
  logic                 dmi_req_ready_i;
  logic                 dmi_resp_valid_i;
  logic [W-1:0]         dmi_resp_data_i;
  logic                 dmi_resp_ready_o;

  modport slave (
    input  req_valid_i, req_data_i, resp_ready_i,
    input  dmi_req_ready_i, dmi_resp_valid_i, dmi_resp_data_i,
    output req_ready_o, resp_valid_o, resp_data_o,
    output dmi_req_valid_o, dmi_req_data_o, dmi_resp_ready_o
  );

  modport master (
    output req_valid_i, req_data_i, resp_ready_i,
    output dmi_req_ready_i, dmi_resp_valid_i, dmi_resp_data_i,
    input  req_ready_o, resp_valid_o, resp_data_o,
    input  dmi_req_valid_o, dmi_req_data_o, dmi_resp_ready_o
  );
endinterface

// File: rtl/jtag_dmi_arb.sv
// Round-robin arbiter sharing one DMI port between NUM_REQ requesters, one transaction
// in flight at a time, with a response timeout that returns a failed-op packet.
module jtag_dmi_arb #(
  parameter int DMI_ADDR_BITS = 7,
  parameter int DMI_DATA_BITS = 32,
  parameter int DMI_OP_BITS   = 2,
  parameter int NUM_REQ       = 2,
  parameter int TIMEOUT       = 1024
) (
  input logic           clk_i,
  input logic           rst_ni,
  jtag_dmi_arb_if.slave bus
);
  localparam int W  = DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS;
  localparam int OW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic          TO_EN      = (TIMEOUT != 0);
  localparam logic [TW-1:0] T_LAST     = (TIMEOUT == 0) ? {TW{1'b0}} : TW'(TIMEOUT - 1);
  localparam logic [W-1:0]  TIMEOUT_PKT = W'(2'b10);

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_REQ  = 4'b0010,
    S_RESP = 4'b0100,
    S_DONE = 4'b1000
  } state_e;

  state_e             state_r, state_s;
  logic [OW-1:0]      owner_r, last_grant_r, grant_s, cand_s;
  logic               grant_found_s;
  logic [W-1:0]       req_pkt_r, resp_pkt_r, req_sel_s;
  logic [TW-1:0]      timer_r;
  logic               run_r;
  logic [NUM_REQ-1:0] req_ready_s, owner_oh_s;
  logic               accept_s, resp_take_s, timeout_s, timer_clr_s;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    grant_s       = {OW{1'b0}};
    grant_found_s = 1'b0;
    cand_s        = {OW{1'b0}};
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_s = OW'((int'(last_grant_r) + i) % NUM_REQ);
      if (!grant_found_s && bus.req_valid_i[cand_s]) begin
        grant_found_s = 1'b1;
        grant_s       = cand_s;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
    req_sel_s = bus.req_data_i[int'(grant_s)*W +: W];
  end

  // Next-state and handshake decode.
  always_comb begin
    state_s     = state_r;
    req_ready_s = {NUM_REQ{1'b0}};
    accept_s    = 1'b0;
    resp_take_s = 1'b0;
    timeout_s   = 1'b0;
    timer_clr_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (run_r && grant_found_s) begin
          req_ready_s[grant_s] = 1'b1;
          accept_s             = 1'b1;
          state_s              = S_REQ;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_REQ: begin
        if (bus.dmi_req_ready_i) begin
          timer_clr_s = 1'b1;
          state_s     = S_RESP;
        end else begin
          state_s = S_REQ;
        end
      end
      S_RESP: begin
        // A real response beats a timeout landing on the same cycle.
        if (bus.dmi_resp_valid_i) begin
          resp_take_s = 1'b1;
          state_s     = S_DONE;
        end else if (TO_EN && (timer_r == T_LAST)) begin
          timeout_s = 1'b1;
          state_s   = S_DONE;
        end else begin
          state_s = S_RESP;
        end
      end
      S_DONE: begin
        if (bus.resp_ready_i[owner_r]) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_DONE;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State, captured packets, ownership and response timer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r      <= S_IDLE;
      run_r        <= 1'b0;
      owner_r      <= {OW{1'b0}};
      last_grant_r <= OW'(NUM_REQ - 1);
      req_pkt_r    <= {W{1'b0}};
      resp_pkt_r   <= {W{1'b0}};
      timer_r      <= {TW{1'b0}};
    end else begin
      state_r <= state_s;
      run_r   <= 1'b1;
      if (accept_s) begin
        req_pkt_r <= req_sel_s;
        owner_r   <= grant_s;
      end else begin
        req_pkt_r <= req_pkt_r;
      end
      if (resp_take_s) begin
        resp_pkt_r <= bus.dmi_resp_data_i;
      end else if (timeout_s) begin
        resp_pkt_r <= TIMEOUT_PKT;
      end else begin
        resp_pkt_r <= resp_pkt_r;
      end
      if ((state_r == S_DONE) && (state_s == S_IDLE)) begin
        last_grant_r <= owner_r;
      end else begin
        last_grant_r <= last_grant_r;
      end
      if (timer_clr_s) begin
        timer_r <= {TW{1'b0}};
      end else if ((state_r == S_RESP) && (timer_r != {TW{1'b1}})) begin
        timer_r <= timer_r + 1'b1;
      end else begin
        timer_r <= timer_r;
      end
    end
  end

  // Stale DM responses are drained in every state once out of reset.
  always_comb begin
    owner_oh_s           = NUM_REQ'(1) << owner_r;
    bus.req_ready_o      = req_ready_s;
    bus.dmi_req_valid_o  = (state_r == S_REQ);
    bus.dmi_req_data_o   = req_pkt_r;
    bus.dmi_resp_ready_o = run_r;
    bus.resp_valid_o     = (state_r == S_DONE) ? owner_oh_s : {NUM_REQ{1'b0}};
    bus.resp_data_o      = resp_pkt_r;
  end
endmodule

// File: tb/tb_jtag_dmi_arb.sv
// Randomized self-checking bench for jtag_dmi_arb: the bench plays all requesters and the DM,
// predicting grant order, packets and timeout responses from a transaction-level model.
module tb_jtag_dmi_arb;
  localparam int AB = 7;
  localparam int DB = 32;
  localparam int OB = 2;
  localparam int NR = 2;
  localparam int TO = 8;
  localparam int W  = AB + DB + OB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jtag_dmi_arb_if #(.DMI_ADDR_BITS(AB), .DMI_DATA_BITS(DB), .DMI_OP_BITS(OB), .NUM_REQ(NR)) bus ();

  jtag_dmi_arb #(
    .DMI_ADDR_BITS(AB), .DMI_DATA_BITS(DB), .DMI_OP_BITS(OB), .NUM_REQ(NR), .TIMEOUT(TO)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  int         last_grant;
  bit         stale;
  logic [W-1:0] pkt [NR];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rand_word();
    return W'({$urandom(), $urandom()});
  endfunction

  task automatic rand_pkts();
    for (int k = 0; k < NR; k++) pkt[k] = rand_word();
  endtask

  // Round-robin rule: first valid requester after the last one served, with wrap.
  function automatic int model_grant(input logic [NR-1:0] vmask, input int last);
    int g;
    g = -1;
    for (int i = 1; i <= NR; i++) begin
      int c;
      c = (last + i) % NR;
      if (g < 0 && vmask[c]) g = c;
    end
    return g;
  endfunction

  task automatic run_txn(input logic [NR-1:0] vmask, input int wreq, input int rw,
                         input logic [W-1:0] rdata, input int ow);
    int           g;
    int           nresp;
    bit           got;
    logic [NR-1:0] goh;
    logic [W-1:0] exp_resp;
    g   = model_grant(vmask, last_grant);
    goh = NR'(1) << g;
    bus.req_valid_i = vmask;
    for (int k = 0; k < NR; k++) bus.req_data_i[k*W +: W] = pkt[k];
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (bus.req_ready_o != '0) got = 1'b1;
      else tick();
    end
    check_eq("grant", bus.req_ready_o, goh);
    check_eq("idle_dmi_req_valid", bus.dmi_req_valid_o, 1'b0);
    check_eq("idle_resp_valid", bus.resp_valid_o, '0);
    tick();
    bus.req_valid_i[g] = 1'b0;
    // REQ phase; a pending late response from a timed-out transaction is offered here
    for (int c = 0; c <= wreq; c++) begin
      bus.dmi_req_ready_i  = (c == wreq);
      bus.dmi_resp_valid_i = stale;
      bus.dmi_resp_data_i  = rand_word();
      @(negedge clk);
      check_eq("dmi_req_valid", bus.dmi_req_valid_o, 1'b1);
      check_eq("dmi_req_data", bus.dmi_req_data_o, pkt[g]);
      check_eq("req_ready_busy", bus.req_ready_o, '0);
      check_eq("req_dmi_resp_ready", bus.dmi_resp_ready_o, 1'b1);
      tick();
    end
    bus.dmi_req_ready_i  = 1'b0;
    bus.dmi_resp_valid_i = 1'b0;
    stale = 1'b0;
    if (rw <= TO - 1) begin
      nresp    = rw + 1;
      exp_resp = rdata;
    end else begin
      nresp    = TO;
      exp_resp = W'(2'b10);
    end
    for (int c = 0; c < nresp; c++) begin
      bus.dmi_resp_valid_i = (c == rw);
      bus.dmi_resp_data_i  = (c == rw) ? rdata : rand_word();
      @(negedge clk);
      check_eq("resp_dmi_resp_ready", bus.dmi_resp_ready_o, 1'b1);
      check_eq("resp_early_valid", bus.resp_valid_o, '0);
      check_eq("resp_dmi_req_valid", bus.dmi_req_valid_o, 1'b0);
      tick();
    end
    bus.dmi_resp_valid_i = 1'b0;
    stale = (rw > TO - 1);
    // DONE phase; non-owner resp_ready bits are toggled and must be ignored
    for (int c = 0; c <= ow; c++) begin
      bus.resp_ready_i = (c == ow) ? goh : (NR'($urandom()) & ~goh);
      @(negedge clk);
      check_eq("resp_valid", bus.resp_valid_o, goh);
      check_eq("resp_data", bus.resp_data_o, exp_resp);
      check_eq("done_req_ready", bus.req_ready_o, '0);
      tick();
    end
    bus.resp_ready_i = '0;
    last_grant = g;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_req_ready"}, bus.req_ready_o, '0);
    check_eq({tag, "_resp_valid"}, bus.resp_valid_o, '0);
    check_eq({tag, "_resp_data"}, bus.resp_data_o, '0);
    check_eq({tag, "_dmi_req_valid"}, bus.dmi_req_valid_o, 1'b0);
    check_eq({tag, "_dmi_req_data"}, bus.dmi_req_data_o, '0);
    check_eq({tag, "_dmi_resp_ready"}, bus.dmi_resp_ready_o, 1'b0);
  endtask

  task automatic reset_mid();
    bit got;
    rand_pkts();
    bus.req_valid_i = 2'b11;
    for (int k = 0; k < NR; k++) bus.req_data_i[k*W +: W] = pkt[k];
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (bus.req_ready_o != '0) got = 1'b1;
      else tick();
    end
    check_eq("rst_pre_grant", bus.req_ready_o, NR'(1) << model_grant(2'b11, last_grant));
    tick();
    bus.req_valid_i     = '0;
    bus.dmi_req_ready_i = 1'b1;
    @(negedge clk);
    check_eq("rst_pre_dmi_req_valid", bus.dmi_req_valid_o, 1'b1);
    tick();
    bus.dmi_req_ready_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    last_grant = NR - 1;
    stale      = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NR-1:0] vmask;
    bus.req_valid_i      = '1;
    bus.req_data_i       = '0;
    bus.resp_ready_i     = '0;
    bus.dmi_req_ready_i  = 1'b0;
    bus.dmi_resp_valid_i = 1'b0;
    bus.dmi_resp_data_i  = '0;
    last_grant = NR - 1;
    stale      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    bus.req_valid_i = '0;
    tick();

    // Round-robin with both requesters always valid: expect 0,1,0,1
    for (int t = 0; t < 4; t++) begin
      rand_pkts();
      run_txn(2'b11, 0, 0, rand_word(), 0);
    end

    // Single request from requester 0, DM answers after 3 cycles
    rand_pkts();
    pkt[0] = {7'h10, 32'h0000_0000, 2'b01};
    run_txn(2'b01, 0, 3, {7'h00, 32'hDEAD_BEEF, 2'b00}, 0);

    // Timeout, then a late response during the next REQ that must be discarded
    rand_pkts();
    run_txn(2'b01, 0, 100, rand_word(), 0);
    rand_pkts();
    run_txn(2'b11, 0, 2, rand_word(), 1);

    // Back-pressure on both downstream request and owner response
    rand_pkts();
    run_txn(2'b11, 5, 1, rand_word(), 4);

    // Response valid on the very cycle the timer expires
    rand_pkts();
    run_txn(2'b10, 0, TO - 1, rand_word(), 0);

    // Reset in RESP, then requester 0 must win the next grant
    reset_mid();
    rand_pkts();
    run_txn(2'b11, 0, 0, rand_word(), 0);

    for (int t = 0; t < 30; t++) begin
      rand_pkts();
      vmask = NR'($urandom_range(1, 3));
      run_txn(vmask, $urandom_range(0, 3), $urandom_range(0, TO + 1), rand_word(),
              $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
    $finish;
  end
endmodule
